// File: rtl/unified_memory_arbiter.sv
// Arbitrates the fetch stage and the MEM stage onto one single-port, fixed-latency RAM.
// Pipeline stall is held until the access of each requesting stage completes.
module unified_memory_arbiter #(
   parameter int unsigned MEM_LATENCY  = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [63:0] mem_addr,
   input  logic [63:0] mem_wdata,
   output logic [63:0] mem_rdata,
   output logic        mem_ready,
   output logic        pipeline_stall,
   output logic        ram_en,
   output logic        ram_we,
   output logic [63:0] ram_addr,
   output logic [63:0] ram_wdata,
   input  logic [63:0] ram_rdata
);

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(MEM_LATENCY - 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t              state;
   logic                gnt_if;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [CNT_W-1:0]    lat_cnt;
   logic [CNT_W-1:0]    starve_cnt;

   // Arbitration, request latching, latency countdown and starvation tracking
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         gnt_if     <= 1'b0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_cnt    <= '0;
         starve_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (if_req && (!mem_req || starve_cnt == STARVE_MAX)) begin
                  gnt_if     <= 1'b1;
                  lat_we     <= 1'b0;
                  lat_addr   <= if_addr;
                  lat_wdata  <= '0;
                  starve_cnt <= '0;
                  state      <= ACCESS;
               end else if (mem_req) begin
                  gnt_if    <= 1'b0;
                  lat_we    <= mem_we;
                  lat_addr  <= mem_addr;
                  lat_wdata <= mem_wdata;
                  if (if_req && starve_cnt < STARVE_MAX)
                     starve_cnt <= starve_cnt + CNT_W'(1);
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (lat_we) begin
                  state <= RESP;
               end else begin
                  lat_cnt <= LAT_INIT;
                  state   <= (MEM_LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt - CNT_W'(1);
               if (lat_cnt == CNT_W'(1))
                  state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // RAM strobes and completion signals decode straight from the state register
   assign ram_en    = (state == ACCESS);
   assign ram_we    = ram_en & lat_we;
   assign ram_addr  = lat_addr;
   assign ram_wdata = lat_wdata;

   assign if_ready  = (state == RESP) &  gnt_if;
   assign mem_ready = (state == RESP) & ~gnt_if;

   // Read data is steered through only during the completion cycle
   assign if_rdata  = if_ready ? (lat_addr[2] ? ram_rdata[63:32] : ram_rdata[31:0]) : '0;
   assign mem_rdata = mem_ready ? ram_rdata : '0;

   assign pipeline_stall = (if_req & ~if_ready) | (mem_req & ~mem_ready);

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench for unified_memory_arbiter: cycle vectors plus hand-written corner sequences.
// A second instance runs with a single-cycle RAM latency.
module tb_unified_memory_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req, mem_req, mem_we;
   logic [63:0] if_addr, mem_addr, mem_wdata;

   logic [31:0] if_rdata, if_rdata1;
   logic        if_ready, if_ready1, mem_ready, mem_ready1;
   logic [63:0] mem_rdata, mem_rdata1;
   logic        pipeline_stall, pipeline_stall1;
   logic        ram_en, ram_en1, ram_we, ram_we1;
   logic [63:0] ram_addr, ram_addr1, ram_wdata, ram_wdata1;
   logic [63:0] ram_rdata, ram_rdata1;

   int n_cmp  = 0;
   int n_fail = 0;
   int g;

   always #5 clock = ~clock;

   unified_memory_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pipeline_stall(pipeline_stall),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   unified_memory_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_ready(if_ready1),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata1), .mem_ready(mem_ready1), .pipeline_stall(pipeline_stall1),
      .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
      .ram_rdata(ram_rdata1)
   );

   function automatic logic [63:0] init_word(input int i);
      if (i == 2) return 64'hAAAA_AAAA_BBBB_BBBB;
      return {32'hC0DE_0000 | 32'(i), 32'h0000_F000 | 32'(i)};
   endfunction

   // RAM model, latency 2: data is driven only in the cycle it is due
   logic [63:0] ram0 [128];
   logic        v0a, v0b;
   logic [63:0] d0a, d0b;
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 128; i++) ram0[i] <= init_word(i);
         v0a <= 1'b0; v0b <= 1'b0; d0a <= '0; d0b <= '0;
      end else begin
         if (ram_en && ram_we) ram0[ram_addr[9:3]] <= ram_wdata;
         v0a <= ram_en && !ram_we;
         d0a <= ram0[ram_addr[9:3]];
         v0b <= v0a;
         d0b <= d0a;
      end
   end
   assign ram_rdata = v0b ? d0b : 64'hDEAD_BEEF_DEAD_BEEF;

   // RAM model, latency 1
   logic [63:0] ram1 [128];
   logic        v1a;
   logic [63:0] d1a;
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 128; i++) ram1[i] <= init_word(i);
         v1a <= 1'b0; d1a <= '0;
      end else begin
         if (ram_en1 && ram_we1) ram1[ram_addr1[9:3]] <= ram_wdata1;
         v1a <= ram_en1 && !ram_we1;
         d1a <= ram1[ram_addr1[9:3]];
      end
   end
   assign ram_rdata1 = v1a ? d1a : 64'hDEAD_BEEF_DEAD_BEEF;

   typedef struct {
      logic        if_req;
      logic [63:0] if_addr;
      logic        mem_req;
      logic        mem_we;
      logic [63:0] mem_addr;
      logic [63:0] mem_wdata;
      logic        en;
      logic        we;
      logic [63:0] addr;
      logic        ifr;
      logic [31:0] ifd;
      logic        mr;
      logic        chk_md;
      logic [63:0] md;
      logic        stall;
   } vec_t;

   vec_t tv [18];

   function automatic vec_t mk(input logic ir, input logic [63:0] ia, input logic mq, input logic mw,
                               input logic [63:0] ma, input logic [63:0] wd, input logic en, input logic we,
                               input logic [63:0] ad, input logic ifr, input logic [31:0] ifd,
                               input logic mr, input logic cm, input logic [63:0] md, input logic st);
      vec_t v;
      v.if_req = ir; v.if_addr = ia; v.mem_req = mq; v.mem_we = mw; v.mem_addr = ma; v.mem_wdata = wd;
      v.en = en; v.we = we; v.addr = ad; v.ifr = ifr; v.ifd = ifd; v.mr = mr; v.chk_md = cm; v.md = md;
      v.stall = st;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      if_addr = '0; mem_addr = '0; mem_wdata = '0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      next_cycle();
   endtask

   logic [63:0] exp_ga [6];
   logic [3:0]  exp_sc [6];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_ga = '{64'h200, 64'h200, 64'h200, 64'h200, 64'h100, 64'h200};
      exp_sc = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

      //        if_req addr     mem req we addr    wdata   en we addr   ifr ifd           mr cm md      stall
      tv[0]  = mk(1, 64'h14, 0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  0, 32'h0,        0, 1, 64'h0,    1);
      tv[1]  = mk(1, 64'h14, 0, 0, 64'h0,  64'h0,    1, 0, 64'h14, 0, 32'h0,        0, 1, 64'h0,    1);
      tv[2]  = mk(1, 64'h14, 0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  0, 32'h0,        0, 1, 64'h0,    1);
      tv[3]  = mk(1, 64'h14, 0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  1, 32'hAAAAAAAA, 0, 1, 64'h0,    0);
      tv[4]  = mk(0, 64'h0,  0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  0, 32'h0,        0, 1, 64'h0,    0);
      tv[5]  = mk(0, 64'h0,  1, 1, 64'h40, 64'h1234, 0, 0, 64'h0,  0, 32'h0,        0, 1, 64'h0,    1);
      tv[6]  = mk(0, 64'h0,  1, 1, 64'h40, 64'h1234, 1, 1, 64'h40, 0, 32'h0,        0, 1, 64'h0,    1);
      tv[7]  = mk(0, 64'h0,  1, 1, 64'h40, 64'h1234, 0, 0, 64'h0,  0, 32'h0,        1, 0, 64'h0,    0);
      tv[8]  = mk(0, 64'h0,  1, 0, 64'h40, 64'h0,    0, 0, 64'h0,  0, 32'h0,        0, 1, 64'h0,    1);
      tv[9]  = mk(0, 64'h0,  1, 0, 64'h40, 64'h0,    1, 0, 64'h40, 0, 32'h0,        0, 1, 64'h0,    1);
      tv[10] = mk(0, 64'h0,  1, 0, 64'h40, 64'h0,    0, 0, 64'h0,  0, 32'h0,        0, 1, 64'h0,    1);
      tv[11] = mk(0, 64'h0,  1, 0, 64'h40, 64'h0,    0, 0, 64'h0,  0, 32'h0,        1, 1, 64'h1234, 0);
      tv[12] = mk(0, 64'h0,  0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  0, 32'h0,        0, 1, 64'h0,    0);
      tv[13] = mk(1, 64'h10, 0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  0, 32'h0,        0, 1, 64'h0,    1);
      tv[14] = mk(1, 64'h10, 0, 0, 64'h0,  64'h0,    1, 0, 64'h10, 0, 32'h0,        0, 1, 64'h0,    1);
      tv[15] = mk(1, 64'h10, 0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  0, 32'h0,        0, 1, 64'h0,    1);
      tv[16] = mk(1, 64'h10, 0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  1, 32'hBBBBBBBB, 0, 1, 64'h0,    0);
      tv[17] = mk(0, 64'h0,  0, 0, 64'h0,  64'h0,    0, 0, 64'h0,  0, 32'h0,        0, 1, 64'h0,    0);

      // Reset state
      reset = 1'b0;
      if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      if_addr = '0; mem_addr = '0; mem_wdata = '0;
      #22;
      chk("reset ram_en",    64'(ram_en), 64'h0);
      chk("reset ram_we",    64'(ram_we), 64'h0);
      chk("reset ram_addr",  ram_addr, 64'h0);
      chk("reset ram_wdata", ram_wdata, 64'h0);
      chk("reset if_ready",  64'(if_ready), 64'h0);
      chk("reset mem_ready", 64'(mem_ready), 64'h0);
      chk("reset if_rdata",  64'(if_rdata), 64'h0);
      chk("reset mem_rdata", mem_rdata, 64'h0);
      chk("reset stall",     64'(pipeline_stall), 64'h0);
      chk("reset starve",    64'(dut.starve_cnt), 64'h0);
      reset = 1'b1;
      next_cycle();

      // Fetch, store, load, fetch of the low word
      for (int i = 0; i < 18; i++) begin
         if_req = tv[i].if_req; if_addr = tv[i].if_addr;
         mem_req = tv[i].mem_req; mem_we = tv[i].mem_we;
         mem_addr = tv[i].mem_addr; mem_wdata = tv[i].mem_wdata;
         @(negedge clock);
         chk($sformatf("v%0d ram_en", i),    64'(ram_en), 64'(tv[i].en));
         chk($sformatf("v%0d ram_we", i),    64'(ram_we), 64'(tv[i].we));
         if (tv[i].en) chk($sformatf("v%0d ram_addr", i), ram_addr, tv[i].addr);
         chk($sformatf("v%0d if_ready", i),  64'(if_ready), 64'(tv[i].ifr));
         chk($sformatf("v%0d if_rdata", i),  64'(if_rdata), 64'(tv[i].ifd));
         chk($sformatf("v%0d mem_ready", i), 64'(mem_ready), 64'(tv[i].mr));
         if (tv[i].chk_md) chk($sformatf("v%0d mem_rdata", i), mem_rdata, tv[i].md);
         chk($sformatf("v%0d stall", i),     64'(pipeline_stall), 64'(tv[i].stall));
         next_cycle();
      end

      // Contention: both held high, fetch forced in after four MEM grants
      do_reset();
      if_req = 1'b1; if_addr = 64'h100;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h200;
      g = 0;
      for (int c = 0; c < 80 && g < 6; c++) begin
         @(negedge clock);
         if (ram_en) begin
            chk($sformatf("grant%0d addr", g), ram_addr, exp_ga[g]);
            chk($sformatf("grant%0d starve_cnt", g), 64'(dut.starve_cnt), 64'(exp_sc[g]));
            g++;
         end
         next_cycle();
      end
      chk("contention grant count", 64'(g), 64'd6);

      // Reset pulled low during WAIT
      do_reset();
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h18;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      #1;
      chk("midreset ram_en", 64'(ram_en), 64'h0);
      chk("midreset mem_ready", 64'(mem_ready), 64'h0);
      mem_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         chk($sformatf("midreset c%0d mem_ready", c), 64'(mem_ready), 64'h0);
         chk($sformatf("midreset c%0d ram_en", c), 64'(ram_en), 64'h0);
      end
      @(negedge clock);
      reset = 1'b1;
      next_cycle();
      mem_req = 1'b1; mem_addr = 64'h18;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         chk($sformatf("postreset c%0d ram_en", c), 64'(ram_en), 64'(c == 1));
         chk($sformatf("postreset c%0d mem_ready", c), 64'(mem_ready), 64'(c == 3));
         if (c == 3) chk("postreset mem_rdata", mem_rdata, 64'hC0DE0003_0000F003);
         next_cycle();
         if (c == 3) mem_req = 1'b0;
      end

      // Address changed during WAIT is ignored
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h28;
      for (int c = 0; c < 4; c++) begin
         if (c == 2) mem_addr = 64'h30;
         @(negedge clock);
         if (c == 1) chk("latched ram_addr access", ram_addr, 64'h28);
         if (c == 2) chk("latched ram_addr wait", ram_addr, 64'h28);
         chk($sformatf("latched c%0d mem_ready", c), 64'(mem_ready), 64'(c == 3));
         if (c == 3) chk("latched mem_rdata", mem_rdata, 64'hC0DE0005_0000F005);
         next_cycle();
      end
      mem_req = 1'b0;

      // Single-cycle latency instance never waits
      do_reset();
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h18;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         chk($sformatf("lat1 c%0d ram_en", c), 64'(ram_en1), 64'(c == 1));
         chk($sformatf("lat1 c%0d mem_ready", c), 64'(mem_ready1), 64'(c == 2));
         if (c == 2) begin
            chk("lat1 mem_rdata", mem_rdata1, 64'hC0DE0003_0000F003);
            chk("lat1 stall", 64'(pipeline_stall1), 64'h0);
         end
         next_cycle();
         if (c == 2) mem_req = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
